// File: rtl/inv_shift_rows_stage.sv
// AES InvShiftRows pipeline stage: row r of the state is rotated right by r bytes at capture.
// Define INV_SHIFT_ROWS_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module inv_shift_rows_stage #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] blk_count
);

   // Column-major state: byte s_k sits at [127-8k -: 8], row k%4, column k/4.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      return {s[127:120], s[23:16],   s[47:40],   s[71:64],
              s[95:88],   s[119:112], s[15:8],    s[39:32],
              s[63:56],   s[87:80],   s[111:104], s[7:0],
              s[31:24],   s[55:48],   s[79:72],   s[103:96]};
   endfunction

   logic [127:0]     w_in_data;
   logic             w_accept;
   logic             w_drain;
   logic             r_out_valid;
   logic [127:0]     r_out_data;
   logic [TAG_W-1:0] r_out_tag;
   logic [CNT_W-1:0] r_blk_count;

   assign w_in_data = inv_shift_rows(in_data);
   assign w_accept  = in_valid && in_ready;
   assign w_drain   = r_out_valid && out_ready;

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;
   assign blk_count = r_blk_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blk_count <= '0;
      end else if (w_drain) begin
         r_blk_count <= r_blk_count + 1'b1;
      end
   end

`ifdef INV_SHIFT_ROWS_SKID_EN
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic [127:0]     r_skid_data;
   logic [TAG_W-1:0] r_skid_tag;

   // Only rst gates the registered ready; out_ready never reaches in_ready.
   assign in_ready = r_in_ready && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_tag   <= '0;
         r_skid_data <= '0;
         r_skid_tag  <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_in_data;
                  r_out_tag   <= in_tag;
                  r_state     <= FULL;
               end
            end
            FULL: begin
               if (w_accept && w_drain) begin
                  r_out_data <= w_in_data;
                  r_out_tag  <= in_tag;
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
                  r_state     <= EMPTY;
               end else if (w_accept) begin
                  r_skid_data <= w_in_data;
                  r_skid_tag  <= in_tag;
                  r_in_ready  <= 1'b0;
                  r_state     <= SKID;
               end
            end
            SKID: begin
               if (w_drain) begin
                  r_out_data <= r_skid_data;
                  r_out_tag  <= r_skid_tag;
                  r_in_ready <= 1'b1;
                  r_state    <= FULL;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end
`else
   assign in_ready = !rst && (!r_out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_tag   <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_in_data;
         r_out_tag   <= in_tag;
      end else if (w_drain) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Randomized scoreboard bench for inv_shift_rows_stage, with a second CNT_W=4 instance for counter wrap.
module tb_inv_shift_rows_stage;

   typedef struct {
      logic [127:0] d;
      logic [3:0]   t;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [3:0]   in_tag = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic [3:0]   out_tag;
   logic [15:0]  blk_count;

   logic         w4_in_ready;
   logic         w4_out_valid;
   logic [127:0] w4_out_data;
   logic [3:0]   w4_out_tag;
   logic [3:0]   w4_blk_count;

   int n_checks = 0;
   int n_errors = 0;
   int n_cnt    = 0;
   int n_out    = 0;

   beat_t pend_q[$];
   beat_t exp_q[$];
   logic         acc_last   = 1'b0;
   logic         prev_stall = 1'b0;
   logic [127:0] prev_d     = '0;
   logic [3:0]   prev_t     = '0;
   logic [127:0] last_d     = '0;
   logic [3:0]   last_t     = '0;

   always #5 clk = ~clk;

   inv_shift_rows_stage #(.TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .blk_count(blk_count)
   );

   inv_shift_rows_stage #(.TAG_W(4), .CNT_W(4)) dut_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w4_in_ready),
      .in_data(in_data), .in_tag(in_tag), .out_valid(w4_out_valid), .out_ready(out_ready),
      .out_data(w4_out_data), .out_tag(w4_out_tag), .blk_count(w4_blk_count)
   );

   // Reference: output row r, column c takes input row r, column (c - r) mod 4.
   function automatic logic [127:0] ref_isr(input logic [127:0] s);
      logic [7:0]   b [16];
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(4*c+r) -: 8] = b[4*((c - r + 4) % 4) + r];
      return o;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic rdy, input logic offer);
      logic  ir_before;
      beat_t e;
      @(negedge clk);
      if (acc_last) begin
         in_valid = 1'b0;
         acc_last = 1'b0;
      end
      ir_before = in_ready;
      out_ready = rdy;
      if (!in_valid && offer && pend_q.size() > 0) begin
         in_valid = 1'b1;
         in_data  = pend_q[0].d;
         in_tag   = pend_q[0].t;
      end
      #1;
`ifdef INV_SHIFT_ROWS_SKID_EN
      chk("in_ready_indep", in_ready, ir_before);
`endif
      chk("blk_count", blk_count, n_cnt[15:0]);
      chk("blk_count_w4", w4_blk_count, n_cnt[3:0]);
      chk("w4_valid", w4_out_valid, out_valid);
      if (prev_stall) begin
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_data", out_data, prev_d);
         chk("stall_tag", out_tag, prev_t);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_tag", out_tag, e.t);
         end
         n_cnt++;
         n_out++;
         last_d = out_data;
         last_t = out_tag;
      end
      if (in_valid && in_ready) begin
         exp_q.push_back('{ref_isr(in_data), in_tag});
         pend_q.delete(0);
         acc_last = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_t     = out_tag;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1;
         #1;
         chk("rst_in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      acc_last = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 128'h0);
      chk("rst_out_tag", out_tag, 4'h0);
      chk("rst_blk_count", blk_count, 16'h0);
      pend_q.delete();
      exp_q.delete();
      n_cnt = 0;
      prev_stall = 1'b0;
   endtask

   task automatic push_beat(input logic [127:0] d, input logic [3:0] t);
      pend_q.push_back('{d, t});
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      int n0;
      int guard;
      logic [3:0] bp_pat;

      do_reset(2);

      // Directed mapping vector
      push_beat(128'h00010203_04050607_08090a0b_0c0d0e0f, 4'h3);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      chk("map_data", last_d, 128'h000d0a07_04010e0b_0805020f_0c090603);
      chk("map_tag", last_t, 4'h3);
      cycle(1'b1, 1'b0);
      chk("map_cnt", blk_count, 16'd1);

      // Round trip of encrypt ShiftRows output
      push_beat(128'h00050a0f_04090e03_080d0207_0c01060b, 4'h9);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      chk("rt_data", last_d, 128'h00010203_04050607_08090a0b_0c0d0e0f);

      // Back-pressure: 8 beats, out_ready pattern 1,0,0,1
      bp_pat = 4'b1001;
      n0 = n_out;
      for (int i = 0; i < 8; i++) push_beat(rand128(), i[3:0]);
      for (int i = 0; i < 80 && (n_out - n0) < 8; i++) cycle(bp_pat[i % 4], 1'b1);
      chk("bp_delivered", n_out - n0, 8);
      cycle(1'b1, 1'b0);
      chk("bp_blk_count", blk_count, 16'(n0 + 8));

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if (pend_q.size() < 4) push_beat(rand128(), 4'($urandom_range(0, 15)));
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      guard = 0;
      while ((pend_q.size() > 0 || exp_q.size() > 0 || (in_valid && !acc_last)) && guard < 100) begin
         cycle(1'b1, 1'b1);
         guard++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      cycle(1'b1, 1'b0);

      // Streaming at full rate: 100 beats in 101 cycles
      for (int i = 0; i < 100; i++) push_beat(rand128(), 4'(i));
      n0 = n_out;
      repeat (101) cycle(1'b1, 1'b1);
      chk("stream_count", n_out - n0, 100);

      // Reset with beats held under back-pressure
      push_beat(rand128(), 4'hA);
      push_beat(rand128(), 4'hB);
      repeat (4) cycle(1'b0, 1'b1);
      chk("held_valid", out_valid, 1'b1);
      do_reset(1);
      repeat (6) cycle(1'b1, 1'b0);
      chk("post_rst_cnt", blk_count, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
